// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED toggle protocol: command bytes, colour
// bit positions, the all-off pattern and the common state encoding.
package rgb_pkg;

  localparam logic [7:0] CMD_R = 8'd82;
  localparam logic [7:0] CMD_G = 8'd71;
  localparam logic [7:0] CMD_B = 8'd66;

  localparam int R_IDX = 2;
  localparam int G_IDX = 1;
  localparam int B_IDX = 0;

  localparam logic [2:0] RGB_OFF = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2
  } rgbState_t;

  // One-hot of the highest-priority pending toggle (R before G before B).
  function automatic logic [2:0] pickToggle(input logic [2:0] pending);
    logic [2:0] onehot;
    onehot = 3'b000;
    if (pending[R_IDX])      onehot[R_IDX] = 1'b1;
    else if (pending[G_IDX]) onehot[G_IDX] = 1'b1;
    else if (pending[B_IDX]) onehot[B_IDX] = 1'b1;
    return onehot;
  endfunction

  function automatic logic [7:0] toggleCmd(input logic [2:0] onehot);
    logic [7:0] cmd;
    cmd = 8'd0;
    if (onehot[R_IDX])      cmd = CMD_R;
    else if (onehot[G_IDX]) cmd = CMD_G;
    else if (onehot[B_IDX]) cmd = CMD_B;
    return cmd;
  endfunction

endpackage

// File: rtl/rgb_gap_timer.sv
// Loadable down-counter that paces the idle gap between command bytes.
// o_done is high whenever the count has reached zero.
module rgb_gap_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_loadValue,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_dec && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/rgb_cmd_encoder.sv
// Turns a requested LED colour into the minimal run of R/G/B toggle bytes,
// tracking the remote LED state in a local shadow register.
module rgb_cmd_encoder
  import rgb_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_target,
  input  logic       i_targetValid,
  output logic       o_targetReady,
  input  logic       i_resync,
  output logic [7:0] o_cmd,
  output logic       o_cmdValid,
  input  logic       i_cmdReady,
  output logic [2:0] o_shadowRgb,
  output logic       o_busy
);

  rgbState_t  r_state;
  logic [2:0] r_pending;
  logic [2:0] r_shadow;
  logic [7:0] r_cmd;
  logic       r_cmdValid;

  logic       w_accept;
  logic       w_handshake;
  logic [2:0] w_sentBit;
  logic [2:0] w_nextPending;
  logic [2:0] w_newPending;
  logic       w_gapDone;

  assign o_targetReady = (r_state == ST_IDLE) && !i_resync;
  assign w_accept      = i_targetValid && o_targetReady;
  assign w_handshake   = r_cmdValid && i_cmdReady;
  assign w_sentBit     = pickToggle(r_pending);
  assign w_nextPending = r_pending & ~w_sentBit;
  assign w_newPending  = i_target ^ r_shadow;

  // Resync beats any in-flight byte: a byte offered in that cycle is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_pending  <= 3'b000;
      r_shadow   <= RGB_OFF;
      r_cmd      <= 8'd0;
      r_cmdValid <= 1'b0;
    end else if (i_resync) begin
      r_state    <= ST_IDLE;
      r_pending  <= 3'b000;
      r_shadow   <= RGB_OFF;
      r_cmdValid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pending <= w_newPending;
            if (w_newPending != 3'b000) begin
              r_state    <= ST_SEND;
              r_cmd      <= toggleCmd(pickToggle(w_newPending));
              r_cmdValid <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (w_handshake) begin
            r_shadow  <= r_shadow ^ w_sentBit;
            r_pending <= w_nextPending;
            if (w_nextPending == 3'b000) begin
              r_cmdValid <= 1'b0;
              r_state    <= ST_IDLE;
            end else if (GAP_CYCLES == 0) begin
              r_cmd <= toggleCmd(pickToggle(w_nextPending));
            end else begin
              r_cmdValid <= 1'b0;
              r_state    <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (w_gapDone) begin
            r_state    <= ST_SEND;
            r_cmd      <= toggleCmd(pickToggle(r_pending));
            r_cmdValid <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cmdValid <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
      rgb_gap_timer #(
        .W(GAP_W)
      ) u_gapTimer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (i_resync || (r_state == ST_SEND && w_handshake && w_nextPending != 3'b000)),
        .i_loadValue (i_resync ? '0 : GAP_LOAD),
        .i_dec       (r_state == ST_GAP),
        .o_done      (w_gapDone)
      );
    end else begin : g_noGap
      // Without a gap the GAP state is never entered; the flag is simply true.
      assign w_gapDone = (GAP_W > 0);
    end
  endgenerate

  assign o_cmd       = r_cmd;
  assign o_cmdValid  = r_cmdValid;
  assign o_shadowRgb = r_shadow;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rgb_cmd_encoder.sv
// Directed bench for rgb_cmd_encoder: one instance back-to-back (no gap) and
// one with a 3-cycle gap; emitted bytes are checked against a queue scoreboard.
module tb_rgb_cmd_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [2:0] t0, t3;
  logic       tv0, tv3, rs0, rs3, rdy0, rdy3;
  logic       tr0, tr3, v0, v3, busy0, busy3;
  logic [7:0] cmd0, cmd3;
  logic [2:0] sh0, sh3;

  logic [7:0] q0[$];
  logic [7:0] q3[$];
  logic [7:0] exp0, exp3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rgb_cmd_encoder #(.GAP_CYCLES(0), .GAP_W(8)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_target(t0), .i_targetValid(tv0),
    .o_targetReady(tr0), .i_resync(rs0), .o_cmd(cmd0), .o_cmdValid(v0),
    .i_cmdReady(rdy0), .o_shadowRgb(sh0), .o_busy(busy0)
  );

  rgb_cmd_encoder #(.GAP_CYCLES(3), .GAP_W(8)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_target(t3), .i_targetValid(tv3),
    .o_targetReady(tr3), .i_resync(rs3), .o_cmd(cmd3), .o_cmdValid(v3),
    .i_cmdReady(rdy3), .o_shadowRgb(sh3), .o_busy(busy3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] target);
    t0  = target;
    tv0 = 1'b1;
    tick();
    tv0 = 1'b0;
  endtask

  // Scoreboard: every accepted byte (not masked by reset/resync) must match the queue head.
  always @(negedge clk) begin
    if (!reset && !rs0 && v0 && rdy0) begin
      if (q0.size() == 0) checkOutput("dut0 unexpected byte", {24'd0, cmd0}, 32'hFFFF_FFFF);
      else begin
        exp0 = q0.pop_front();
        checkOutput("dut0 byte", {24'd0, cmd0}, {24'd0, exp0});
      end
    end
    if (!reset && !rs3 && v3 && rdy3) begin
      if (q3.size() == 0) checkOutput("dut3 unexpected byte", {24'd0, cmd3}, 32'hFFFF_FFFF);
      else begin
        exp3 = q3.pop_front();
        checkOutput("dut3 byte", {24'd0, cmd3}, {24'd0, exp3});
      end
    end
  end

  initial begin
    t0 = 3'b111; t3 = 3'b111;
    tv0 = 1'b0; tv3 = 1'b0; rs0 = 1'b0; rs3 = 1'b0; rdy0 = 1'b0; rdy3 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;

    checkOutput("reset shadow", sh0, 3'b111);
    checkOutput("reset cmd", cmd0, 8'd0);
    checkOutput("reset cmdValid", v0, 1'b0);
    checkOutput("reset targetReady", tr0, 1'b1);
    checkOutput("reset busy", busy0, 1'b0);
    checkOutput("reset shadow gap", sh3, 3'b111);

    // Single R toggle, latency 1, ready again two cycles after accept
    rdy0 = 1'b1;
    q0.push_back(8'd82);
    applyStimulus(3'b011);
    checkOutput("single cmdValid", v0, 1'b1);
    checkOutput("single cmd", cmd0, 8'd82);
    checkOutput("single busy", busy0, 1'b1);
    checkOutput("single targetReady low", tr0, 1'b0);
    tick();
    checkOutput("single targetReady back", tr0, 1'b1);
    checkOutput("single shadow", sh0, 3'b011);
    checkOutput("single cmdValid drop", v0, 1'b0);

    // Three back-to-back bytes in R,G,B order
    q0.push_back(8'd82); q0.push_back(8'd71); q0.push_back(8'd66);
    applyStimulus(3'b100);
    checkOutput("b2b byte1", cmd0, 8'd82);
    tick();
    checkOutput("b2b valid2", v0, 1'b1);
    checkOutput("b2b byte2", cmd0, 8'd71);
    tick();
    checkOutput("b2b valid3", v0, 1'b1);
    checkOutput("b2b byte3", cmd0, 8'd66);
    tick();
    checkOutput("b2b done valid", v0, 1'b0);
    checkOutput("b2b shadow", sh0, 3'b100);

    // Resync during byte 2 with ready high and a competing Target
    q0.push_back(8'd82);
    applyStimulus(3'b011);
    tick();
    checkOutput("resync pre byte2", cmd0, 8'd71);
    rs0 = 1'b1; t0 = 3'b110; tv0 = 1'b1;
    #1;
    checkOutput("resync targetReady", tr0, 1'b0);
    tick();
    rs0 = 1'b0; tv0 = 1'b0;
    checkOutput("resync cmdValid", v0, 1'b0);
    checkOutput("resync shadow", sh0, 3'b111);
    checkOutput("resync busy", busy0, 1'b0);
    q0.push_back(8'd66);
    applyStimulus(3'b110);
    checkOutput("post resync byte", cmd0, 8'd66);
    tick();
    checkOutput("post resync shadow", sh0, 3'b110);

    // Target equal to shadow emits nothing
    q0.push_back(8'd71); q0.push_back(8'd66);
    applyStimulus(3'b101);
    tick(); tick();
    checkOutput("to 101 shadow", sh0, 3'b101);
    applyStimulus(3'b101);
    for (int i = 0; i < 3; i++) begin
      checkOutput("equal cmdValid", v0, 1'b0);
      checkOutput("equal targetReady", tr0, 1'b1);
      tick();
    end

    // Downstream stall holds the first byte stable
    rdy0 = 1'b0;
    q0.push_back(8'd82);
    applyStimulus(3'b001);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall cmd", cmd0, 8'd82);
      checkOutput("stall valid", v0, 1'b1);
      checkOutput("stall shadow", sh0, 3'b101);
      tick();
    end
    rdy0 = 1'b1;
    tick();
    checkOutput("stall released valid", v0, 1'b0);
    checkOutput("stall released shadow", sh0, 3'b001);

    // Gap instance: three bytes each separated by exactly 3 idle cycles
    rdy3 = 1'b1;
    q3.push_back(8'd82); q3.push_back(8'd71); q3.push_back(8'd66);
    t3 = 3'b000; tv3 = 1'b1;
    tick();
    tv3 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checkOutput("gap valid pattern", v3, 32'((k <= 9) && ((k - 1) % 4 == 0)));
      tick();
    end
    checkOutput("gap shadow", sh3, 3'b000);
    checkOutput("gap busy", busy3, 1'b0);

    // Reset mid-sequence also clears Cmd
    q3.push_back(8'd82);
    t3 = 3'b111; tv3 = 1'b1;
    tick();
    tv3 = 1'b0;
    tick();
    checkOutput("mid gap busy", busy3, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset cmd", cmd3, 8'd0);
    checkOutput("midreset valid", v3, 1'b0);
    checkOutput("midreset shadow", sh3, 3'b111);
    checkOutput("midreset busy", busy3, 1'b0);

    tick();
    checkOutput("dut0 queue drained", q0.size(), 0);
    checkOutput("dut3 queue drained", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rgb_cmd_encoder.md
Name: rgb_cmd_encoder

Overview:
Command-side encoder for the RGB LED toggle protocol. It accepts a requested LED colour, compares it against a shadow copy of the remote LED state, and emits the minimal sequence of ASCII toggle bytes that drives the remote FSM to that colour. The bytes are 'R' = 82, 'G' = 71 and 'B' = 66.
- Sits between host/control logic and the UART transmit path (or directly on the LED FSM's Cmd bus) over a valid/ready byte handshake.

Parameters:
GAP_CYCLES, 0, idle cycles inserted after each accepted byte before the next byte is presented (0 = back-to-back)
GAP_W, 8, width of the gap counter; GAP_CYCLES must be < 2**GAP_W

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Target  input  3  requested colour, active-low: bit2 = R, bit1 = G, bit0 = B (0 = LED on)
TargetValid  input  1  Target is valid
TargetReady  output  1  encoder idle and able to accept a Target
Resync  input  1  remote FSM has been reset; force shadow to all-off
Cmd  output  8  command byte (82/71/66 only)
CmdValid  output  1  Cmd valid
CmdReady  input  1  downstream accepts Cmd
ShadowRGB  output  3  encoder's model of remote LED state, active-low
Busy  output  1  sequence in progress (IDLE state not active)

Behaviour:
- Reset values:
  - ShadowRGB = 3'b111
  - Cmd = 8'd0
  - CmdValid = 0
  - TargetReady = 1
  - Busy = 0
  - gap counter = 0
  - state = IDLE
- States: IDLE, SEND, GAP.
- Target handshake:
  - Accepted on a cycle where TargetValid & TargetReady.
  - TargetReady = 1 only in IDLE with Resync low.
  - On accept, latch Pending = Target XOR ShadowRGB. A 1 in Pending means that bit needs a toggle.
- IDLE -> SEND when Pending != 0. Stay in IDLE when Pending == 0: no bytes are emitted and TargetReady stays 1.
- SEND:
  - Cmd is registered. Byte selection uses fixed priority R (bit2), then G (bit1), then B (bit0), taking the highest set Pending bit.
  - CmdValid rises the cycle after Target accept (latency 1).
  - Cmd and CmdValid hold stable until CmdReady is sampled high.
- On byte handshake (CmdValid & CmdReady):
  - Toggle the matching ShadowRGB bit and clear the matching Pending bit, both in the same cycle.
  - If Pending becomes 0: CmdValid drops next cycle and the block goes to IDLE.
  - Otherwise, with GAP_CYCLES = 0: present the next byte with CmdValid held high (back-to-back).
  - Otherwise, with GAP_CYCLES > 0: CmdValid = 0 and go to GAP.
- GAP: counter loads GAP_CYCLES-1 and decrements; at 0 return to SEND and present the next byte. Exactly GAP_CYCLES cycles pass with CmdValid low between bytes.
- After the last byte, ShadowRGB == latched Target.
- Busy = (state != IDLE).
- Resync:
  - Has priority over everything, in any state.
  - Next cycle: ShadowRGB = 111, Pending = 0, CmdValid = 0, state = IDLE.
  - A byte presented in the Resync cycle counts as dropped, even if CmdReady was high, and the shadow is not toggled.
  - Resync together with TargetValid: the Target is not accepted, because TargetReady is low.
- Reset mid-sequence: identical to Resync plus Cmd cleared to 0.
- CmdReady held low indefinitely: the block stalls in SEND with outputs stable. There is no timeout.
- Maximum sequence is 3 bytes; worst-case duration is 3 + 2*GAP_CYCLES handshake cycles plus stall time.

Decomposition:
- Shared package (rgb_pkg) holds:
  - Command byte constants: CMD_R = 8'd82, CMD_G = 8'd71, CMD_B = 8'd66.
  - Colour bit indices: R = 2, G = 1, B = 0.
  - RGB_OFF = 3'b111.
  - The 3-bit state encoding, so that the LED FSM and this encoder share one definition.
- Sub-module: rgb_gap_timer, a loadable down-counter with a done flag. It is instantiated only when GAP_CYCLES > 0.
- Priority byte select stays inline.

Test Plan:
- Reset, GAP_CYCLES = 0. Apply Target = 3'b011 (R on) with CmdReady = 1 -> one byte 82 one cycle after accept; ShadowRGB = 011; TargetReady back high 2 cycles after accept.
- Shadow 011. Apply Target = 3'b100 (G, B on, R off) with CmdReady = 1 -> bytes 82, 71, 66 on consecutive cycles; ShadowRGB ends 100.
- GAP_CYCLES = 3. Target 000 from 111 -> bytes 82, 71, 66, each separated by exactly 3 cycles of CmdValid = 0.
- CmdReady held low 10 cycles during the first byte -> Cmd = 82 and CmdValid stable throughout; accepted on the first CmdReady high; ShadowRGB unchanged until then.
- Target equal to shadow (shadow 101, Target = 101) -> no CmdValid pulse; TargetReady stays 1.
- Resync asserted during byte 2 of a 3-byte sequence, with CmdReady = 1 in that cycle -> CmdValid = 0 next cycle, ShadowRGB = 111, IDLE; a following Target 110 emits only byte 66.
